mem_access_controller: RTL and testbench
========================================

MEM_ACCESS_CONTROLLER -- requirements
Module: mem_access_controller

Interface
REQ-001 SHALL have parameter RSP_TIMEOUT, default 16: maximum number of cycles spent in WAIT_RSP.
REQ-002 SHALL have parameter RX_GAP, default 255: maximum idle cycles allowed between frame bytes.
REQ-003 SHALL use one clock and a synchronous, active-low reset; all state SHALL update on posedge clk.
REQ-004 Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- rx_valid  in  1  received UART byte strobe, one cycle per byte
- rx_byte  in  8  received UART byte
- tx_ready  in  1  UART transmitter can accept a byte
- tx_valid  out  1  byte offered to transmitter
- tx_byte  out  8  byte to transmit
- enable  in  1  CPU running; memory access is allowed only when this is 0
- write_mem_req  out  1  one-cycle memory request strobe
- target_mem_type  out  1  memory select: 1 = instruction memory, 0 = data memory
- target_addr  out  9  word address
- rw_flag  out  1  1 = write, 0 = read
- wr_data  out  32  write data
- imem_rsp_valid  in  1  instruction-memory read data ready
- imem_rsp  in  42  {valid, addr[8:0], data[31:0]}
- dmem_rsp_valid  in  1  data-memory read data ready
- dmem_rsp  in  42  same format as imem_rsp
- busy  out  1  high whenever state is not IDLE

Function
REQ-005 Frame byte 0 (CMD) SHALL be decoded as: bit7 = rw, bit6 = mem_type, bit0 = addr[8]; bits 5:1 are ignored.
REQ-006 Frame byte 1 SHALL be addr[7:0]. A write frame SHALL carry 4 more bytes of data, MSB first; a read frame SHALL end after byte 1.
REQ-007 States SHALL be IDLE, ADDR, DATA, ISSUE, WAIT_RSP, SEND, ACK.
REQ-008 IDLE: on rx_valid, the controller SHALL latch CMD and go to ADDR.
REQ-009 ADDR: on rx_valid, the controller SHALL latch addr[7:0]; it SHALL then go to DATA if rw=1, otherwise to ISSUE.
REQ-010 DATA: a 2-bit byte counter SHALL shift in data MSB first; after the 4th byte the controller SHALL go to ISSUE.
REQ-011 In ADDR and DATA, a gap counter SHALL reset on each rx_valid; when it reaches RX_GAP the frame SHALL be discarded and the state SHALL return to IDLE with no output.
REQ-012 ISSUE with enable=0: write_mem_req SHALL pulse high for exactly one cycle, with target_* / rw_flag / wr_data stable that cycle; next state is ACK for a write, WAIT_RSP for a read.
REQ-013 ISSUE with enable=1: no request SHALL be issued; the controller SHALL load NAK byte 0xEE and go to ACK.
REQ-014 target_mem_type, target_addr, rw_flag and wr_data SHALL hold their latched values from ISSUE until the next ISSUE.
REQ-015 WAIT_RSP: the controller SHALL capture imem_rsp when target_mem_type=1 and imem_rsp_valid=1, or dmem_rsp when target_mem_type=0 and dmem_rsp_valid=1; the response from the non-selected memory SHALL be ignored.
REQ-016 WAIT_RSP: after a capture the controller SHALL go to SEND; after RSP_TIMEOUT cycles without a capture it SHALL load 0xEE and go to ACK.
REQ-017 SEND SHALL transmit 6 bytes: {6'b0, rsp[41:40]}, rsp[39:32], rsp[31:24], rsp[23:16], rsp[15:8], rsp[7:0].
REQ-018 TX handshake: a byte transfers on a cycle with tx_valid & tx_ready; tx_byte SHALL stay stable while tx_valid=1 and tx_ready=0; the byte index SHALL advance only on transfer.
REQ-019 After the 6th transfer in SEND, the controller SHALL return to IDLE.
REQ-020 ACK SHALL send a single byte: 0xAA for a successful write, 0xEE for a NAK or timeout; after the transfer it SHALL return to IDLE.
REQ-021 rx_valid while in ISSUE, WAIT_RSP, SEND or ACK SHALL be dropped, with no state effect.
REQ-022 rx_valid and a pending tx transfer in the same cycle SHALL each be handled per the rules for the current state, independently.
REQ-023 busy SHALL be the combinational decode of state != IDLE.

Reset
REQ-024 With rst_n=0 at posedge clk: state=IDLE, tx_valid=0, tx_byte=0, write_mem_req=0, target_mem_type=0, target_addr=0, rw_flag=0, wr_data=0, all counters and the captured response cleared.
REQ-025 Reset asserted mid-frame or mid-transmit SHALL abort with no further tx_valid and no write_mem_req.

Verification
REQ-026 Write: enable=0; bytes C0,05,DE,AD,BE,EF -> single pulse with mem_type=1, addr=0x005, rw=1, wr_data=DEADBEEF; then tx byte 0xAA.
REQ-027 Read: enable=0; bytes 01,10 -> pulse with mem_type=0, addr=0x110, rw=0; dmem_rsp=3_10_12345678 after 3 cycles -> tx 03,10,12,34,56,78.
REQ-028 Enable=1 at ISSUE: bytes 40,00 -> no write_mem_req; tx 0xEE.
REQ-029 Timeout: read frame issued, only imem_rsp_valid asserted while target is dmem -> after 16 cycles tx 0xEE.
REQ-030 Backpressure: tx_ready=0 for 10 cycles during SEND -> tx_byte held stable, no byte lost or duplicated.
REQ-031 RX gap: bytes C0,05 then 256 idle cycles -> return to IDLE; next bytes 01,00 decode as a fresh read frame.

Source files
------------

// File: rtl/mem_access_controller.sv
// UART-framed memory access controller: decodes read/write frames, issues a one-cycle
// memory request, and returns either a read response or an ACK/NAK byte.
module mem_access_controller #(
  parameter int RSP_TIMEOUT = 16,
  parameter int RX_GAP      = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_byte,
  input  logic        enable,
  output logic        write_mem_req,
  output logic        target_mem_type,
  output logic [8:0]  target_addr,
  output logic        rw_flag,
  output logic [31:0] wr_data,
  input  logic        imem_rsp_valid,
  input  logic [41:0] imem_rsp,
  input  logic        dmem_rsp_valid,
  input  logic [41:0] dmem_rsp,
  output logic        busy
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_DATA     = 3'd2;
  localparam logic [2:0] S_ISSUE    = 3'd3;
  localparam logic [2:0] S_WAIT_RSP = 3'd4;
  localparam logic [2:0] S_SEND     = 3'd5;
  localparam logic [2:0] S_ACK      = 3'd6;

  localparam logic [7:0] ACK_BYTE = 8'hAA;
  localparam logic [7:0] NAK_BYTE = 8'hEE;

  localparam int GAP_W = $clog2(RX_GAP + 1);
  localparam int TO_W  = $clog2(RSP_TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RX_GAP - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(RSP_TIMEOUT - 1);

  logic [2:0]       r_state;
  logic             r_cmd_rw;
  logic             r_cmd_mt;
  logic [8:0]       r_frame_addr;
  logic [31:0]      r_frame_data;
  logic [1:0]       r_byte_cnt;
  logic [GAP_W-1:0] r_gap;
  logic [TO_W-1:0]  r_to;
  logic [41:0]      r_rsp;
  logic [2:0]       r_tx_idx;
  logic             r_tx_valid;
  logic [7:0]       r_tx_byte;
  logic             r_mem_req;
  logic             r_tgt_mt;
  logic [8:0]       r_tgt_addr;
  logic             r_rw;
  logic [31:0]      r_wr_data;

  logic             w_rsp_hit;
  logic [41:0]      w_rsp_sel;

  // Only the memory addressed by the last issued request may answer.
  assign w_rsp_hit = r_tgt_mt ? imem_rsp_valid : dmem_rsp_valid;
  assign w_rsp_sel = r_tgt_mt ? imem_rsp : dmem_rsp;

  function automatic logic [7:0] rsp_byte(input logic [41:0] rsp, input logic [2:0] idx);
    case (idx)
      3'd0:    rsp_byte = {6'b0, rsp[41:40]};
      3'd1:    rsp_byte = rsp[39:32];
      3'd2:    rsp_byte = rsp[31:24];
      3'd3:    rsp_byte = rsp[23:16];
      3'd4:    rsp_byte = rsp[15:8];
      default: rsp_byte = rsp[7:0];
    endcase
  endfunction

  // NOTE: every register here, including the captured response, is cleared by reset so
  // an aborted frame or transmission leaves nothing behind to leak into the next one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cmd_rw     <= 1'b0;
      r_cmd_mt     <= 1'b0;
      r_frame_addr <= '0;
      r_frame_data <= '0;
      r_byte_cnt   <= '0;
      r_gap        <= '0;
      r_to         <= '0;
      r_rsp        <= '0;
      r_tx_idx     <= '0;
      r_tx_valid   <= 1'b0;
      r_tx_byte    <= '0;
      r_mem_req    <= 1'b0;
      r_tgt_mt     <= 1'b0;
      r_tgt_addr   <= '0;
      r_rw         <= 1'b0;
      r_wr_data    <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the state that
      // was present at the clock edge regardless of statement order.
      r_mem_req <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (rx_valid) begin
            r_cmd_rw        <= rx_byte[7];
            r_cmd_mt        <= rx_byte[6];
            r_frame_addr[8] <= rx_byte[0];
            r_frame_data    <= '0;
            r_gap           <= '0;
            r_state         <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            r_frame_addr[7:0] <= rx_byte;
            r_gap             <= '0;
            r_byte_cnt        <= '0;
            r_state           <= r_cmd_rw ? S_DATA : S_ISSUE;
          end else if (r_gap == GAP_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            r_frame_data <= {r_frame_data[23:0], rx_byte};
            r_gap        <= '0;
            r_byte_cnt   <= r_byte_cnt + 1'b1;
            if (r_byte_cnt == 2'd3) r_state <= S_ISSUE;
          end else if (r_gap == GAP_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        S_ISSUE: begin
          if (enable) begin
            r_tx_valid <= 1'b1;
            r_tx_byte  <= NAK_BYTE;
            r_state    <= S_ACK;
          end else begin
            r_mem_req  <= 1'b1;
            r_tgt_mt   <= r_cmd_mt;
            r_tgt_addr <= r_frame_addr;
            r_rw       <= r_cmd_rw;
            r_wr_data  <= r_frame_data;
            r_to       <= '0;
            if (r_cmd_rw) begin
              r_tx_valid <= 1'b1;
              r_tx_byte  <= ACK_BYTE;
              r_state    <= S_ACK;
            end else begin
              r_state <= S_WAIT_RSP;
            end
          end
        end
        S_WAIT_RSP: begin
          if (w_rsp_hit) begin
            r_rsp      <= w_rsp_sel;
            r_tx_valid <= 1'b1;
            r_tx_byte  <= rsp_byte(w_rsp_sel, 3'd0);
            r_tx_idx   <= '0;
            r_state    <= S_SEND;
          end else if (r_to == TO_LAST) begin
            r_tx_valid <= 1'b1;
            r_tx_byte  <= NAK_BYTE;
            r_state    <= S_ACK;
          end else begin
            r_to <= r_to + 1'b1;
          end
        end
        S_SEND: begin
          if (r_tx_valid && tx_ready) begin
            if (r_tx_idx == 3'd5) begin
              r_tx_valid <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_tx_idx  <= r_tx_idx + 1'b1;
              r_tx_byte <= rsp_byte(r_rsp, r_tx_idx + 3'd1);
            end
          end
        end
        S_ACK: begin
          if (r_tx_valid && tx_ready) begin
            r_tx_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_valid        = r_tx_valid;
  assign tx_byte         = r_tx_byte;
  assign write_mem_req   = r_mem_req;
  assign target_mem_type = r_tgt_mt;
  assign target_addr     = r_tgt_addr;
  assign rw_flag         = r_rw;
  assign wr_data         = r_wr_data;
  assign busy            = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_access_controller.sv
// Directed bench for mem_access_controller: write, read, NAK, timeout, backpressure,
// RX gap abort and reset abort, with hand-computed expectations.
module tb_mem_access_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        tx_ready;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        enable;
  logic        write_mem_req;
  logic        target_mem_type;
  logic [8:0]  target_addr;
  logic        rw_flag;
  logic [31:0] wr_data;
  logic        imem_rsp_valid;
  logic [41:0] imem_rsp;
  logic        dmem_rsp_valid;
  logic [41:0] dmem_rsp;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  int          cyc = 0;
  int          pulse_cnt = 0;
  int          pulse_cyc = 0;
  int          tx_start_cyc = 0;
  logic        prev_tx_valid = 1'b0;
  logic        p_mt;
  logic [8:0]  p_addr;
  logic        p_rw;
  logic [31:0] p_data;
  logic [7:0]  tx_q[$];

  mem_access_controller #(.RSP_TIMEOUT(16), .RX_GAP(255)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rx_valid        (rx_valid),
    .rx_byte         (rx_byte),
    .tx_ready        (tx_ready),
    .tx_valid        (tx_valid),
    .tx_byte         (tx_byte),
    .enable          (enable),
    .write_mem_req   (write_mem_req),
    .target_mem_type (target_mem_type),
    .target_addr     (target_addr),
    .rw_flag         (rw_flag),
    .wr_data         (wr_data),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp        (imem_rsp),
    .dmem_rsp_valid  (dmem_rsp_valid),
    .dmem_rsp        (dmem_rsp),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Observe on the falling edge; inputs change 1 time unit after the rising edge.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (write_mem_req) begin
      pulse_cnt++;
      pulse_cyc = cyc;
      p_mt      = target_mem_type;
      p_addr    = target_addr;
      p_rw      = rw_flag;
      p_data    = wr_data;
    end
    if (tx_valid && !prev_tx_valid) tx_start_cyc = cyc;
    prev_tx_valid = tx_valid;
    if (tx_valid && tx_ready) tx_q.push_back(tx_byte);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick(1);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic expect_tx(input string tag, input int n, input logic [47:0] bytes);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick(1);
      if (tx_q.size() >= n && !busy) done = 1'b1;
    end
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " count"}, 64'(tx_q.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < tx_q.size())
        chk($sformatf("%s b%0d", tag, i), 64'(tx_q[i]), 64'(bytes[8*(n-1-i) +: 8]));
    end
    tx_q.delete();
  endtask

  task automatic respond_dmem(input logic [41:0] rsp);
    dmem_rsp_valid = 1'b1;
    dmem_rsp       = rsp;
    tick(1);
    dmem_rsp_valid = 1'b0;
  endtask

  initial begin
    int base;
    rst_n = 1'b0; rx_valid = 1'b0; rx_byte = '0; tx_ready = 1'b1; enable = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp = '0; dmem_rsp_valid = 1'b0; dmem_rsp = '0;
    tick(2);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst tx_valid", 64'(tx_valid), 64'd0);
    chk("rst tx_byte", 64'(tx_byte), 64'd0);
    chk("rst req", 64'(write_mem_req), 64'd0);
    chk("rst addr", 64'(target_addr), 64'd0);
    chk("rst wr_data", 64'(wr_data), 64'd0);
    rst_n = 1'b1;
    tick(1);

    // Write frame to instruction memory
    base = pulse_cnt;
    send_byte(8'hC0); send_byte(8'h05);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    expect_tx("write ack", 1, 48'hAA);
    chk("write pulses", 64'(pulse_cnt - base), 64'd1);
    chk("write mt", 64'(p_mt), 64'd1);
    chk("write addr", 64'(p_addr), 64'h005);
    chk("write rw", 64'(p_rw), 64'd1);
    chk("write data", 64'(p_data), 64'hDEADBEEF);
    chk("write hold data", 64'(wr_data), 64'hDEADBEEF);

    // Read frame from data memory; a stray imem response must be ignored
    base = pulse_cnt;
    send_byte(8'h01); send_byte(8'h10);
    tick(2);
    imem_rsp_valid = 1'b1; imem_rsp = 42'h2_55_AAAAAAAA;
    tick(1);
    imem_rsp_valid = 1'b0;
    respond_dmem(42'h3_10_12345678);
    expect_tx("read", 6, 48'h03_10_12_34_56_78);
    chk("read pulses", 64'(pulse_cnt - base), 64'd1);
    chk("read mt", 64'(p_mt), 64'd0);
    chk("read addr", 64'(p_addr), 64'h110);
    chk("read rw", 64'(p_rw), 64'd0);

    // CPU running at ISSUE: NAK, no request
    base = pulse_cnt;
    enable = 1'b1;
    send_byte(8'h40); send_byte(8'h00);
    expect_tx("nak", 1, 48'hEE);
    chk("nak pulses", 64'(pulse_cnt - base), 64'd0);
    enable = 1'b0;

    // Timeout: only the non-selected memory answers
    base = pulse_cnt;
    imem_rsp_valid = 1'b1; imem_rsp = 42'h1_22_33334444;
    send_byte(8'h01); send_byte(8'h10);
    expect_tx("timeout", 1, 48'hEE);
    chk("timeout pulses", 64'(pulse_cnt - base), 64'd1);
    chk("timeout latency", 64'(tx_start_cyc - pulse_cyc), 64'd16);
    imem_rsp_valid = 1'b0;

    // Backpressure during SEND, with an rx byte that must be dropped
    base = pulse_cnt;
    tx_ready = 1'b0;
    send_byte(8'h01); send_byte(8'h10);
    tick(2);
    respond_dmem(42'h3_A5_0F1E2D3C);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp valid %0d", i), 64'(tx_valid), 64'd1);
      chk($sformatf("bp byte %0d", i), 64'(tx_byte), 64'h03);
      rx_valid = (i == 4);
      rx_byte  = 8'hC0;
      tick(1);
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    expect_tx("backpressure", 6, 48'h03_A5_0F_1E_2D_3C);
    chk("bp pulses", 64'(pulse_cnt - base), 64'd1);

    // RX gap: frame abandoned after RX_GAP idle cycles
    base = pulse_cnt;
    send_byte(8'hC0); send_byte(8'h05);
    tick(200);
    chk("gap busy early", 64'(busy), 64'd1);
    tick(56);
    chk("gap busy after", 64'(busy), 64'd0);
    chk("gap no tx", 64'(tx_q.size()), 64'd0);
    chk("gap no pulse", 64'(pulse_cnt - base), 64'd0);
    send_byte(8'h01); send_byte(8'h00);
    tick(2);
    respond_dmem(42'h1_00_CAFEF00D);
    expect_tx("gap fresh read", 6, 48'h01_00_CA_FE_F0_0D);
    chk("gap fresh pulses", 64'(pulse_cnt - base), 64'd1);
    chk("gap fresh addr", 64'(p_addr), 64'h100);
    chk("gap fresh rw", 64'(p_rw), 64'd0);

    // Reset mid-frame
    base = pulse_cnt;
    send_byte(8'hC0); send_byte(8'h05); send_byte(8'hDE);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("rst frame busy", 64'(busy), 64'd0);
    chk("rst frame addr", 64'(target_addr), 64'd0);
    tick(20);
    chk("rst frame no pulse", 64'(pulse_cnt - base), 64'd0);
    chk("rst frame no tx", 64'(tx_q.size()), 64'd0);

    // Reset mid-transmit
    tx_ready = 1'b0;
    send_byte(8'h01); send_byte(8'h10);
    tick(2);
    respond_dmem(42'h0_01_00000001);
    chk("rst tx pre valid", 64'(tx_valid), 64'd1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("rst tx valid", 64'(tx_valid), 64'd0);
    chk("rst tx byte", 64'(tx_byte), 64'd0);
    chk("rst tx busy", 64'(busy), 64'd0);
    tx_ready = 1'b1;
    tick(20);
    chk("rst tx nothing sent", 64'(tx_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
